// File: rtl/ssp_sched.sv
// ssp_sched: round-robin scheduler for the SSP write path, with TX-full hold-off and
// optional RX-full drain (enabled by defining SSP_SCHED_RXDRAIN_EN).
module ssp_sched #(
   parameter int DW = 8
) (
   input  logic          PCLK,
   input  logic          CLEAR_B,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   input  logic          SSPTXINTR,
   input  logic          SSPRXINTR,
   input  logic [DW-1:0] PRDATA,
   output logic          PSEL,
   output logic          PWRITE,
   output logic [DW-1:0] PWDATA,
   output logic          rx_valid,
   output logic [DW-1:0] rx_data,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, RDCAP} state_t;
   state_t state;
   logic last_grant, rx_go, accept, gnt1;
`ifdef SSP_SCHED_RXDRAIN_EN
   assign rx_go = SSPRXINTR;
`else
   logic unused_rx;
   assign rx_go = 1'b0;
   assign unused_rx = ^{SSPRXINTR, PRDATA};
`endif
   assign accept = CLEAR_B && state == IDLE && !rx_go && !SSPTXINTR && (req0_valid || req1_valid);
   // On contention the requester not granted last time wins
   assign gnt1 = req1_valid && (!req0_valid || !last_grant);
   assign req0_ready = accept && !gnt1;
   assign req1_ready = accept && gnt1;
   assign busy = state != IDLE;
   always_ff @(posedge PCLK) begin
      if (!CLEAR_B) begin
         state <= IDLE;
         PSEL <= 1'b0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         rx_valid <= 1'b0;
         rx_data <= '0;
         last_grant <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE:
               if (rx_go) begin
                  state <= READ;
                  PSEL <= 1'b1;
                  PWRITE <= 1'b0;
               end else if (accept) begin
                  state <= WRITE;
                  PSEL <= 1'b1;
                  PWRITE <= 1'b1;
                  PWDATA <= gnt1 ? req1_data : req0_data;
                  last_grant <= gnt1;
               end
            WRITE: begin
               state <= IDLE;
               PSEL <= 1'b0;
            end
            READ: begin
               state <= RDCAP;
               PSEL <= 1'b0;
            end
            default: begin
               state <= IDLE;
`ifdef SSP_SCHED_RXDRAIN_EN
               rx_valid <= 1'b1;
               rx_data <= PRDATA;
`endif
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ssp_sched.sv
// tb_ssp_sched: directed stimulus with write/rx scoreboards for ssp_sched.
module tb_ssp_sched;
   localparam int DW = 8;
   logic PCLK = 1'b0, CLEAR_B = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, SSPTXINTR = 1'b0, SSPRXINTR = 1'b0;
   logic [DW-1:0] req0_data = '0, req1_data = '0, PRDATA = '0;
   logic req0_ready, req1_ready, PSEL, PWRITE, rx_valid, busy;
   logic [DW-1:0] PWDATA, rx_data;
   int checks = 0, errs = 0, wr_cnt = 0, base = 0;
   logic [DW-1:0] wq[$], rxq[$];

   ssp_sched #(.DW(DW)) dut (
      .PCLK(PCLK), .CLEAR_B(CLEAR_B),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .SSPTXINTR(SSPTXINTR), .SSPRXINTR(SSPRXINTR), .PRDATA(PRDATA),
      .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every port write strobe and every rx pulse must match the oldest expected entry
   always @(negedge PCLK) begin
      if (PSEL && PWRITE) begin
         wr_cnt++;
         if (wq.size() == 0) chk("wr_unexpected", 8'(wq.size()), 8'd1);
         else chk("wr_data", PWDATA, wq.pop_front());
      end
      if (rx_valid) begin
         if (rxq.size() == 0) chk("rx_unexpected", 8'(rxq.size()), 8'd1);
         else chk("rx_data", rx_data, rxq.pop_front());
      end
   end

   initial begin
      req0_valid = 1'b1;
      req0_data = 8'h77;
      repeat (2) @(negedge PCLK);
      #1;
      chk("rst_rdy0", 8'(req0_ready), 8'd0);
      chk("rst_psel", 8'(PSEL), 8'd0);
      chk("rst_pwdata", PWDATA, 8'h00);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_rxv", 8'(rx_valid), 8'd0);
      chk("rst_rxd", rx_data, 8'h00);
      // reset while the write strobe is on the bus
      @(negedge PCLK) CLEAR_B = 1'b1;
      #1 chk("mw_acc", 8'(req0_ready), 8'd1);
      wq.push_back(8'h77);
      @(negedge PCLK) CLEAR_B = 1'b0;
      #1 chk("mw_busy", 8'(busy), 8'd1);
      @(negedge PCLK);
      #1;
      chk("mw_psel", 8'(PSEL), 8'd0);
      chk("mw_pwdata", PWDATA, 8'h00);
      chk("mw_busy0", 8'(busy), 8'd0);
      chk("mw_rdy0", 8'(req0_ready), 8'd0);
      chk("mw_rdy1", 8'(req1_ready), 8'd0);
      req0_valid = 1'b0;
      @(negedge PCLK) CLEAR_B = 1'b1;
      // single requester
      @(negedge PCLK);
      req0_valid = 1'b1;
      req0_data = 8'hA5;
      #1;
      base = wr_cnt;
      chk("s_rdy0", 8'(req0_ready), 8'd1);
      chk("s_rdy1", 8'(req1_ready), 8'd0);
      wq.push_back(8'hA5);
      @(negedge PCLK);
      req0_valid = 1'b0;
      req0_data = 8'h00;
      #1;
      chk("s_psel", 8'(PSEL), 8'd1);
      chk("s_pwrite", 8'(PWRITE), 8'd1);
      chk("s_pwdata", PWDATA, 8'hA5);
      repeat (3) @(negedge PCLK);
      #1;
      chk("s_count", 8'(wr_cnt - base), 8'd1);
      chk("s_busy", 8'(busy), 8'd0);
      // contention from a fresh reset: 0 wins first, then strict alternation
      @(negedge PCLK) CLEAR_B = 1'b0;
      @(negedge PCLK);
      CLEAR_B = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data = 8'h11;
      req1_data = 8'h22;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (i == 0) base = wr_cnt;
         chk("c_rdy0", 8'(req0_ready), 8'(i % 4 == 0));
         chk("c_rdy1", 8'(req1_ready), 8'(i % 4 == 2));
         if (i % 4 == 0) wq.push_back(8'h11);
         if (i % 4 == 2) wq.push_back(8'h22);
         @(negedge PCLK);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(negedge PCLK);
      #1 chk("c_count", 8'(wr_cnt - base), 8'd4);
      // TX full blocks grants
      @(negedge PCLK);
      req1_valid = 1'b1;
      req1_data = 8'h5A;
      SSPTXINTR = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t_rdy1", 8'(req1_ready), 8'd0);
         chk("t_psel", 8'(PSEL), 8'd0);
         @(negedge PCLK);
      end
      SSPTXINTR = 1'b0;
      #1 chk("t_grant", 8'(req1_ready), 8'd1);
      wq.push_back(8'h5A);
      @(negedge PCLK) req1_valid = 1'b0;
      #1 chk("t_psel1", 8'(PSEL), 8'd1);
`ifdef SSP_SCHED_RXDRAIN_EN
      @(negedge PCLK);
      SSPRXINTR = 1'b1;
      req0_valid = 1'b1;
      req0_data = 8'h99;
      #1 chk("r_rdy0", 8'(req0_ready), 8'd0);
      rxq.push_back(8'h3C);
      @(negedge PCLK) SSPRXINTR = 1'b0;
      #1;
      chk("r_psel", 8'(PSEL), 8'd1);
      chk("r_pwrite", 8'(PWRITE), 8'd0);
      chk("r_rdy0_rd", 8'(req0_ready), 8'd0);
      @(negedge PCLK) PRDATA = 8'h3C;
      #1;
      chk("r_cap_psel", 8'(PSEL), 8'd0);
      chk("r_cap_busy", 8'(busy), 8'd1);
      chk("r_rdy0_cap", 8'(req0_ready), 8'd0);
      @(negedge PCLK) PRDATA = 8'h00;
      #1;
      chk("r_rxv", 8'(rx_valid), 8'd1);
      chk("r_rxd", rx_data, 8'h3C);
      chk("r_rdy0_after", 8'(req0_ready), 8'd1);
      wq.push_back(8'h99);
      @(negedge PCLK) req0_valid = 1'b0;
      #1;
      chk("r_rxv_pulse", 8'(rx_valid), 8'd0);
      chk("r_rxd_hold", rx_data, 8'h3C);
      chk("r_wr_psel", 8'(PSEL), 8'd1);
      chk("r_wr_pwrite", 8'(PWRITE), 8'd1);
      // read wins when both FIFOs report full
      @(negedge PCLK);
      SSPTXINTR = 1'b1;
      SSPRXINTR = 1'b1;
      rxq.push_back(8'h5E);
      @(negedge PCLK);
      SSPTXINTR = 1'b0;
      SSPRXINTR = 1'b0;
      #1;
      chk("rt_psel", 8'(PSEL), 8'd1);
      chk("rt_pwrite", 8'(PWRITE), 8'd0);
      @(negedge PCLK) PRDATA = 8'h5E;
      @(negedge PCLK) PRDATA = 8'h00;
      #1 chk("rt_rxv", 8'(rx_valid), 8'd1);
`else
      @(negedge PCLK);
      SSPRXINTR = 1'b1;
      PRDATA = 8'h3C;
      req0_valid = 1'b1;
      req0_data = 8'h42;
      #1 chk("n_rdy0", 8'(req0_ready), 8'd1);
      wq.push_back(8'h42);
      @(negedge PCLK) req0_valid = 1'b0;
      #1;
      chk("n_psel", 8'(PSEL), 8'd1);
      chk("n_pwrite", 8'(PWRITE), 8'd1);
      repeat (3) @(negedge PCLK);
      #1;
      chk("n_rxv", 8'(rx_valid), 8'd0);
      chk("n_rxd", rx_data, 8'h00);
      chk("n_busy", 8'(busy), 8'd0);
      SSPRXINTR = 1'b0;
`endif
      repeat (2) @(negedge PCLK);
      #1;
      chk("sb_wq_empty", 8'(wq.size()), 8'd0);
      chk("sb_rxq_empty", 8'(rxq.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end
endmodule

// File: doc/ssp_sched.md
# ssp_sched

Host-side scheduler for the synchronous serial port.
- Shares the port's single parallel write path between two requesters using round-robin arbitration.
- Holds writes off while the port's TX FIFO is full.
- Optionally drains received words whenever the port's RX FIFO reports full.
- Sits between the two requester blocks and the port's PSEL/PWRITE/PWDATA/PRDATA interface, in the same PCLK domain.

## Interface
- DW, 8, data word width; must match the port's word width.

- PCLK  input  1  clock; all state changes on posedge.
- CLEAR_B  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 has a word to transmit.
- req0_data  input  DW  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a word to transmit.
- req1_data  input  DW  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle (combinational).
- SSPTXINTR  input  1  port TX FIFO full.
- SSPRXINTR  input  1  port RX FIFO full.
- PRDATA  input  DW  port read data; valid the cycle after a read strobe.
- PSEL  output  1  port select, registered.
- PWRITE  output  1  1 = write, 0 = read; registered.
- PWDATA  output  DW  word to port, registered.
- rx_valid  output  1  one-cycle pulse; rx_data holds a drained word.
- rx_data  output  DW  last drained word, registered.
- busy  output  1  state != IDLE.

## Operation
The scheduler is a state machine with four states: IDLE, WRITE, READ, RDCAP.

**IDLE**
- Priority 1: if SSPRXINTR=1 (RX drain compiled in), go to READ. No requester is accepted this cycle.
- Priority 2: otherwise, if SSPTXINTR=0 and any reqN_valid=1:
  - Pick a winner.
  - Assert reqN_ready for the winner only.
  - Capture its data into PWDATA.
  - Go to WRITE.
- Otherwise stay in IDLE. Both ready outputs are 0.

**Arbitration**
- Only one valid: that requester wins.
- Both valid: the requester not recorded in last_grant wins.
- last_grant updates on every accepted write.
- Reset value of last_grant is 1, so requester 0 wins the first contention.

**WRITE** (1 cycle)
- PSEL=1, PWRITE=1, PWDATA = captured word.
- Next state is IDLE.
- No request is accepted in WRITE. This gives SSPTXINTR one cycle to reflect the write before the next full check.

**READ** (1 cycle)
- PSEL=1, PWRITE=0, PWDATA held.
- Next state is RDCAP.

**RDCAP** (1 cycle)
- PSEL=0.
- rx_data <= PRDATA, and rx_valid pulses high in the following cycle.
- Next state is IDLE.
- If SSPRXINTR is still high, IDLE re-enters READ.

**Data handling**
- The rx consumer has no backpressure. rx_data stays stable until the next drain.
- Requester data may change freely except in the cycle it is accepted.

**Reset**
- CLEAR_B=0 at any posedge, in any state, forces IDLE.
- Register resets: PSEL=0, PWRITE=0, PWDATA=0, rx_valid=0, rx_data=0, last_grant=1.
- req0_ready and req1_ready are 0 while CLEAR_B=0.
- A write or read in flight is abandoned. No ready pulse and no rx_valid pulse are produced.

## Timing
- Write latency: accept at cycle t (reqN_ready=1) → PSEL/PWRITE=1 with the word at cycle t+1 → back in IDLE at t+2.
- Write throughput: maximum one word per 2 cycles. With both requesters continuously valid, grants alternate 0,1,0,1.
- Read sequence: SSPRXINTR seen in IDLE at t → READ strobe at t+1 → capture at t+2 → rx_valid=1 at t+3 → IDLE decision at t+3.
- SSPTXINTR=1 in IDLE blocks all grants. Grants resume in the first IDLE cycle after it drops.
- SSPRXINTR and SSPTXINTR are sampled only in IDLE.
- SSPTXINTR=1 and SSPRXINTR=1 together: the read proceeds.

## Configuration
- SSP_SCHED_RXDRAIN_EN defined: RX drain logic as described. Reads take priority over writes.
- SSP_SCHED_RXDRAIN_EN undefined:
  - SSPRXINTR and PRDATA are ignored.
  - READ and RDCAP are unreachable.
  - PWRITE is 1 whenever PSEL=1.
  - rx_valid=0 and rx_data=0 permanently.

## Test plan
- Reset mid-WRITE: CLEAR_B=0 in the WRITE cycle → next cycle PSEL=0, PWDATA=0, busy=0, both readies 0.
- Single requester: req0 sends 0xA5 with TX not full → req0_ready at t; PSEL=1, PWRITE=1, PWDATA=0xA5 at t+1; only one strobe.
- Contention: both valid continuously with data 0x11 / 0x22 → PWDATA sequence 0x11, 0x22, 0x11, 0x22, one strobe every 2 cycles.
- TX full: SSPTXINTR=1 for 5 cycles with req1 valid → no ready and no PSEL during those cycles; grant in the first cycle after SSPTXINTR drops.
- RX drain (macro on): SSPRXINTR=1 with PRDATA=0x3C presented after the strobe → read strobe (PWRITE=0) at t+1; rx_valid=1 with rx_data=0x3C at t+3; a pending write is deferred until after the drain.
- Macro off: SSPRXINTR=1 and req0 valid → write granted immediately; rx_valid never asserts.
